// File: rtl/i2s_rx.sv
// I2S (Philips) receiver: oversamples BCLK/LRCLK/SDATA in the i_clk domain and
// deserialises stereo sample pairs into a one-entry valid/ready output register.
module i2s_rx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bclk,
  input  logic              i_lrclk,
  input  logic              i_sdata,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_locked
);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] IDX_PRE  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] IDX_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [2:0] bclk_sync_q;
  logic [1:0] lrclk_sync_q;
  logic [1:0] sdata_sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignment makes each stage take the previous stage's
      // old value, so the chain really is two (three) flops deep.
      bclk_sync_q  <= {bclk_sync_q[1:0], i_bclk};
      lrclk_sync_q <= {lrclk_sync_q[0], i_lrclk};
      sdata_sync_q <= {sdata_sync_q[0], i_sdata};
    end
  end

  logic bclk_rise;
  logic lr_smp;
  logic sd_smp;

  // lrclk/sdata come from sync2 so they line up with the sync2-based edge detect
  assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lr_smp    = lrclk_sync_q[1];
  assign sd_smp    = sdata_sync_q[1];

  // ---------------------------------------------------------------------------
  // Slot tracking
  // ---------------------------------------------------------------------------
  logic             lr_prev_q, lr_prev_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] idx_inc;
  logic             boundary;
  logic             bnd_fall;
  logic             bnd_rise;
  logic             data_edge;
  logic             last_edge;
  logic             slot_done;

  assign idx_inc   = (bit_idx_q == IDX_MAX) ? bit_idx_q : bit_idx_q + CNT_W'(1);
  assign boundary  = bclk_rise && (lr_smp != lr_prev_q);
  assign bnd_fall  = boundary && !lr_smp;
  assign bnd_rise  = boundary && lr_smp;
  assign data_edge = bclk_rise && !boundary && (idx_inc <= IDX_LAST);
  assign last_edge = bclk_rise && !boundary && (bit_idx_q == IDX_PRE);
  // Evaluated at a boundary: the slot just ending reached index DATA_W
  assign slot_done = (bit_idx_q >= IDX_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    bit_idx_d = bit_idx_q;
    lr_prev_d = lr_prev_q;
    if (bclk_rise) begin
      lr_prev_d = lr_smp;
      bit_idx_d = boundary ? '0 : idx_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lr_prev_q <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      lr_prev_q <= lr_prev_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   cap_left;
  logic   cap_right;
  logic   pair_done;
  logic   frame_err_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SYNC: begin
        if (bnd_fall) state_d = S_LEFT;
      end
      S_LEFT: begin
        if (bnd_rise) state_d = slot_done ? S_RIGHT : S_SYNC;
      end
      S_RIGHT: begin
        // A short right slot still ends on a real 1->0 edge, so relock at once
        if (bnd_fall) state_d = S_LEFT;
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_comb begin
    cap_left    = 1'b0;
    cap_right   = 1'b0;
    pair_done   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_LEFT: begin
        cap_left    = data_edge;
        frame_err_d = bnd_rise && !slot_done;
      end
      S_RIGHT: begin
        cap_right   = data_edge;
        pair_done   = last_edge;
        frame_err_d = bnd_fall && !slot_done;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel shift registers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] left_sr_q, left_sr_d;
  logic [DATA_W-2:0] right_sr_q, right_sr_d;
  logic [DATA_W-1:0] right_word;

  // The right LSB is still on the wire in the completing cycle
  assign right_word = {right_sr_q, sd_smp};

  always_comb begin
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    if (cap_left)  left_sr_d  = {left_sr_q[DATA_W-2:0], sd_smp};
    if (cap_right) right_sr_d = {right_sr_q[DATA_W-3:0], sd_smp};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left_sr_q  <= '0;
      right_sr_q <= '0;
    end else begin
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q;
  logic              locked_q;
  logic              load;

  assign load = pair_done && (!valid_q || i_ready);

  always_comb begin
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = pair_done && !load;
    if (load) begin
      left_d  = left_sr_q;
      right_d = right_word;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      locked_q    <= (state_d != S_SYNC);
    end
  end

  assign o_left      = left_q;
  assign o_right     = right_q;
  assign o_valid     = valid_q;
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;
  assign o_locked    = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: directed frame table, overrun and reset
// sequences, and randomized frames against a queue of expected sample pairs.
module tb_i2s_rx;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              bclk  = 1'b0;
  logic              lrclk = 1'b0;
  logic              sdata = 1'b0;
  logic              ready = 1'b1;
  logic [DATA_W-1:0] o_left;
  logic [DATA_W-1:0] o_right;
  logic              o_valid;
  logic              o_frame_err;
  logic              o_overrun;
  logic              o_locked;

  i2s_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_bclk      (bclk),
    .i_lrclk     (lrclk),
    .i_sdata     (sdata),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_locked    (o_locked)
  );

  int errors = 0;
  int checks = 0;
  int pairs_seen = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    int                len_l;
    int                len_r;
    int                exp_pairs;
    int                exp_err;
    logic              exp_locked;
  } vec_t;

  pair_t exp_q[$];
  pair_t mon_exp;
  vec_t  vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Consumer: ready changes just after the active edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(1, 0));
    endcase
  end

  // Monitor: every accepted pair must be the oldest expected pair
  always @(negedge clk) begin
    if (o_frame_err) err_seen++;
    if (o_overrun) ovr_seen++;
    if (o_valid && ready) begin
      pairs_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got %h/%h, expected none", o_left, o_right);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pair_left", 32'(o_left), 32'(mon_exp.l));
        check("pair_right", 32'(o_right), 32'(mon_exp.r));
      end
    end
  end

  // One BCLK period (i_clk/4): data and word select change while BCLK is low
  task automatic bclk_edge(input logic lr, input logic sd);
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (2) @(negedge clk);
    bclk = 1'b1;
    @(negedge clk);
  endtask

  // Slot of len BCLKs: edge 0 is the boundary, edges 1..DATA_W carry w MSB
  // first, everything else is junk that must be ignored.
  task automatic send_slot(input logic lr, input int len, input logic [DATA_W-1:0] w);
    logic b;
    for (int k = 0; k < len; k++) begin
      if (k >= 1 && k <= DATA_W) b = w[DATA_W-k];
      else b = 1'($urandom_range(1, 0));
      bclk_edge(lr, b);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int len_l, input int len_r);
    send_slot(1'b0, len_l, l);
    send_slot(1'b1, len_r, r);
  endtask

  task automatic expect_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
  endtask

  int   p0, e0, o0;
  logic nz;
  logic [DATA_W-1:0] rl, rr;

  initial begin
    // Errors from a short right slot surface on the next frame's first edge,
    // so they are expected in the following row.
    vecs[0] = '{16'h8001, 16'h7FFE, 32, 32, 1, 0, 1'b1};
    vecs[1] = '{16'h1357, 16'h2468, 10, 32, 0, 1, 1'b0};
    vecs[2] = '{16'hDEAD, 16'hBEEF, 32, 32, 1, 0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0000, 17, 17, 1, 0, 1'b1};
    vecs[4] = '{16'hA5A5, 16'h5A5A, 16, 32, 0, 1, 1'b0};
    vecs[5] = '{16'h0001, 16'h8000, 17, 16, 0, 0, 1'b1};
    vecs[6] = '{16'h4321, 16'h8765, 24, 20, 1, 1, 1'b1};
    vecs[7] = '{16'h0000, 16'hFFFF, 33, 40, 1, 0, 1'b1};

    // Reset held while the I2S pins toggle: every output must stay 0
    nz = 1'b0;
    repeat (40) begin
      @(negedge clk);
      bclk  = 1'($urandom_range(1, 0));
      lrclk = 1'($urandom_range(1, 0));
      sdata = 1'($urandom_range(1, 0));
      nz |= o_valid | o_frame_err | o_overrun | o_locked | (|o_left) | (|o_right);
    end
    check("reset_quiet", 32'(nz), 32'd0);
    bclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // A 0->1 boundary alone must not lock
    send_slot(1'b0, 20, 16'h0000);
    send_slot(1'b1, 20, 16'h0000);
    repeat (6) @(negedge clk);
    check("unlocked_before_fall", 32'(o_locked), 32'd0);

    for (int i = 0; i < 8; i++) begin
      p0 = pairs_seen;
      e0 = err_seen;
      o0 = ovr_seen;
      if (vecs[i].exp_pairs != 0) expect_pair(vecs[i].l, vecs[i].r);
      send_frame(vecs[i].l, vecs[i].r, vecs[i].len_l, vecs[i].len_r);
      repeat (6) @(negedge clk);
      check($sformatf("vec%0d_pairs", i), 32'(pairs_seen - p0), 32'(vecs[i].exp_pairs));
      check($sformatf("vec%0d_frame_err", i), 32'(err_seen - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_overrun", i), 32'(ovr_seen - o0), 32'd0);
      check($sformatf("vec%0d_locked", i), 32'(o_locked), 32'(vecs[i].exp_locked));
    end

    // Consumer stalled for three frames: first pair held, two dropped
    ready_mode = 0;
    repeat (3) @(negedge clk);
    o0 = ovr_seen;
    expect_pair(16'h1234, 16'h5678);
    send_frame(16'h1234, 16'h5678, 32, 32);
    send_frame(16'hAAAA, 16'h5555, 32, 32);
    send_frame(16'h0F0F, 16'hF0F0, 32, 32);
    repeat (6) @(negedge clk);
    check("stall_overruns", 32'(ovr_seen - o0), 32'd2);
    check("stall_valid", 32'(o_valid), 32'd1);
    check("stall_left", 32'(o_left), 32'h1234);
    check("stall_right", 32'(o_right), 32'h5678);
    @(posedge clk);
    ready_mode = 1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop_after_accept", 32'(o_valid), 32'd0);

    // Reset in the middle of a right slot discards the partial frame
    p0 = pairs_seen;
    e0 = err_seen;
    send_slot(1'b0, 32, 16'h1111);
    send_slot(1'b1, 8, 16'h1111);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_valid", 32'(o_valid), 32'd0);
    check("midreset_locked", 32'(o_locked), 32'd0);
    rst_n = 1'b1;
    send_slot(1'b1, 24, 16'h1111);
    check("midreset_relock_wait", 32'(o_locked), 32'd0);
    check("midreset_no_pair", 32'(pairs_seen - p0), 32'd0);
    expect_pair(16'h2222, 16'h3333);
    send_frame(16'h2222, 16'h3333, 32, 32);
    repeat (6) @(negedge clk);
    check("midreset_pairs", 32'(pairs_seen - p0), 32'd1);
    check("midreset_frame_err", 32'(err_seen - e0), 32'd0);

    // Random words, random legal slot lengths, random back-pressure
    ready_mode = 2;
    p0 = pairs_seen;
    e0 = err_seen;
    o0 = ovr_seen;
    for (int f = 0; f < 15; f++) begin
      rl = DATA_W'($urandom);
      rr = DATA_W'($urandom);
      expect_pair(rl, rr);
      send_frame(rl, rr, int'($urandom_range(40, 17)), int'($urandom_range(40, 17)));
    end
    repeat (20) @(negedge clk);
    ready_mode = 1;
    repeat (10) @(negedge clk);
    check("rand_pairs", 32'(pairs_seen - p0), 32'd15);
    check("rand_frame_err", 32'(err_seen - e0), 32'd0);
    check("rand_overrun", 32'(ovr_seen - o0), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
